// File: rtl/vc_scheduler.sv
// rtl/vc_scheduler.sv - weighted round-robin drain of four VC FIFOs onto one output link
module vc_scheduler #(
    parameter int WEIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [3:0]            valid_channel,
    input  logic [1:0]            rndrobin_input,
    input  logic [4*WEIGHT_W-1:0] weights,
    input  logic                  downstream_afull,
    output logic [3:0]            pop,
    output logic [1:0]            grant_vc,
    output logic                  grant_valid,
    output logic                  burst_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE   = 2'b01,
        STALL   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          grant_nx;
    logic [WEIGHT_W-1:0] burst_cnt;
    logic [WEIGHT_W-1:0] cnt_nx;
    logic                done_nx;
    logic                release_grant;
    logic                can_pop;
    logic [WEIGHT_W-1:0] cur_w;
    logic [WEIGHT_W:0]   eff_w;
    logic [WEIGHT_W:0]   cnt_inc;
    logic [2:0]          idle_pick;
    logic [2:0]          rot_pick;

    // Returns {found, index}; search order s, s+1, s+2, s+3 with 2-bit wrap.
    function automatic logic [2:0] first_set(input logic [3:0] v, input logic [1:0] s);
        logic [1:0] idx;
        first_set = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = s + 2'(k);
            if (v[idx]) begin
                first_set = {1'b1, idx};
            end
        end
    endfunction

    assign cur_w     = weights[int'(grant_vc)*WEIGHT_W +: WEIGHT_W];
    assign eff_w     = (cur_w == '0) ? {{WEIGHT_W{1'b0}}, 1'b1} : {1'b0, cur_w};
    assign cnt_inc   = {1'b0, burst_cnt} + {{WEIGHT_W{1'b0}}, 1'b1};
    assign idle_pick = first_set(valid_channel, rndrobin_input);
    // Starting just past the current grant puts the granted channel last in line.
    assign rot_pick  = first_set(valid_channel, grant_vc + 2'd1);

    assign can_pop     = (state == SERVE) && enb && valid_channel[grant_vc] && !downstream_afull;
    assign grant_valid = (state != IDLE);

    always_comb begin
        pop = 4'b0000;
        if (can_pop) begin
            pop[grant_vc] = 1'b1;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant_vc;
        cnt_nx        = burst_cnt;
        done_nx       = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (|valid_channel) begin
                    grant_nx = idle_pick[1:0];
                    cnt_nx   = '0;
                    state_nx = SERVE;
                end
            end
            SERVE: begin
                if (downstream_afull) begin
                    state_nx = STALL;
                end else if (valid_channel[grant_vc] && (cnt_inc < eff_w)) begin
                    cnt_nx = cnt_inc[WEIGHT_W-1:0];
                end else begin
                    release_grant = 1'b1;
                end
            end
            STALL: begin
                if (!downstream_afull) begin
                    state_nx = SERVE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (release_grant) begin
            done_nx = 1'b1;
            cnt_nx  = '0;
            if (rot_pick[2]) begin
                grant_nx = rot_pick[1:0];
            end else begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant_vc   <= 2'b00;
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else if (enb) begin
            state      <= state_nx;
            grant_vc   <= grant_nx;
            burst_cnt  <= cnt_nx;
            burst_done <= done_nx;
        end else begin
            burst_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vc_scheduler.sv
// tb/tb_vc_scheduler.sv - directed self-checking bench for vc_scheduler
module tb_vc_scheduler;

    localparam int WEIGHT_W = 3;

    logic                  clk;
    logic                  rst;
    logic                  enb;
    logic [3:0]            valid_channel;
    logic [1:0]            rndrobin_input;
    logic [4*WEIGHT_W-1:0] weights;
    logic                  downstream_afull;
    logic [3:0]            pop;
    logic [1:0]            grant_vc;
    logic                  grant_valid;
    logic                  burst_done;

    int checks;
    int errors;

    vc_scheduler #(.WEIGHT_W(WEIGHT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .enb              (enb),
        .valid_channel    (valid_channel),
        .rndrobin_input   (rndrobin_input),
        .weights          (weights),
        .downstream_afull (downstream_afull),
        .pop              (pop),
        .grant_vc         (grant_vc),
        .grant_valid      (grant_valid),
        .burst_done       (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE with rst released, one cycle before the first grant edge.
    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enb = 1'b1;
        valid_channel = 4'hF;
        rndrobin_input = 2'd1;
        weights = {3'd2, 3'd2, 3'd2, 3'd2};
        downstream_afull = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++;
            if ({pop, grant_vc, grant_valid, burst_done} !== 8'h00) begin
                errors++;
                $display("FAIL reset[%0d] pop=%h gvc=%0d gv=%b bd=%b required all 0",
                         i, pop, grant_vc, grant_valid, burst_done);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] ep [0:9];
        logic       ebd [0:9];
        ep  = '{4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4};
        ebd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        weights = {3'd2, 3'd2, 3'd2, 3'd2};
        valid_channel = 4'hF;
        rndrobin_input = 2'd2;
        do_reset();
        #1;
        checks++;
        if (pop !== 4'd0) begin
            errors++;
            $display("FAIL rot_idle pop=%h required 0", pop);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            checks++;
            if (pop !== ep[i] || burst_done !== ebd[i] || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot[%0d] pop=%h bd=%b gv=%b required pop=%h bd=%b gv=1",
                         i, pop, burst_done, grant_valid, ep[i], ebd[i]);
            end
        end
    endtask

    task automatic test_weights_empty();
        logic [3:0] ep [0:13];
        logic       ebd [0:13];
        ep  = '{4'd2, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8,
                4'd2, 4'd8, 4'd8, 4'd0, 4'd2, 4'd2};
        ebd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        weights = {3'd7, 3'd2, 3'd0, 3'd2};
        valid_channel = 4'b1010;
        rndrobin_input = 2'd0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick();
            valid_channel = (i >= 11) ? 4'b0010 : 4'b1010;
            #1;
            checks++;
            if (pop !== ep[i] || burst_done !== ebd[i]) begin
                errors++;
                $display("FAIL wgt[%0d] pop=%h bd=%b required pop=%h bd=%b",
                         i, pop, burst_done, ep[i], ebd[i]);
            end
        end
        checks++;
        if (grant_vc !== 2'd1) begin
            errors++;
            $display("FAIL wgt_empty_grant gvc=%0d required 1", grant_vc);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ep [0:8];
        logic       eaf [0:8];
        ep  = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
        eaf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        weights = {3'd2, 3'd2, 3'd2, 3'd4};
        valid_channel = 4'b0001;
        rndrobin_input = 2'd0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            downstream_afull = eaf[i];
            #1;
            checks++;
            if (pop !== ep[i] || grant_vc !== 2'd0 || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp[%0d] pop=%h gvc=%0d gv=%b required pop=%h gvc=0 gv=1",
                         i, pop, grant_vc, grant_valid, ep[i]);
            end
            if (i == 3) begin
                checks++;
                if (dut.state !== 2'b10) begin
                    errors++;
                    $display("FAIL bp_stall_state state=%b required 10", dut.state);
                end
            end
            if (i == 7 || i == 8) begin
                checks++;
                if (burst_done !== (i == 8)) begin
                    errors++;
                    $display("FAIL bp_done[%0d] bd=%b required %b", i, burst_done, i == 8);
                end
            end
        end
    endtask

    task automatic test_single_idle();
        weights = {3'd2, 3'd2, 3'd2, 3'd1};
        valid_channel = 4'b0001;
        rndrobin_input = 2'd3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (pop !== 4'd1 || grant_vc !== 2'd0 || burst_done !== (i > 0)) begin
                errors++;
                $display("FAIL single[%0d] pop=%h gvc=%0d bd=%b required pop=1 gvc=0 bd=%b",
                         i, pop, grant_vc, burst_done, i > 0);
            end
        end
        tick();
        valid_channel = 4'b0000;
        #1;
        checks++;
        if (pop !== 4'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_cycle pop=%h gv=%b required pop=0 gv=1", pop, grant_valid);
        end
        tick();
        #1;
        checks++;
        if (grant_valid !== 1'b0 || burst_done !== 1'b1 || pop !== 4'd0) begin
            errors++;
            $display("FAIL to_idle gv=%b bd=%b pop=%h required gv=0 bd=1 pop=0",
                     grant_valid, burst_done, pop);
        end
        tick();
        #1;
        checks++;
        if (burst_done !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold bd=%b gv=%b required bd=0 gv=0", burst_done, grant_valid);
        end
    endtask

    task automatic test_enable_reset();
        logic [3:0] ep [0:6];
        logic       een [0:6];
        ep  = '{4'd4, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4};
        een = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        weights = {3'd2, 3'd4, 3'd2, 3'd2};
        valid_channel = 4'b0100;
        rndrobin_input = 2'd0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            enb = een[i];
            #1;
            checks++;
            if (pop !== ep[i] || grant_vc !== 2'd2 || burst_done !== (i == 6)) begin
                errors++;
                $display("FAIL enb[%0d] pop=%h gvc=%0d bd=%b required pop=%h gvc=2 bd=%b",
                         i, pop, grant_vc, burst_done, ep[i], i == 6);
            end
            if (i == 2) begin
                checks++;
                if (dut.burst_cnt !== 3'd1) begin
                    errors++;
                    $display("FAIL enb_frozen_cnt cnt=%0d required 1", dut.burst_cnt);
                end
            end
        end
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || burst_done !== 1'b0 || pop !== 4'd0 || grant_vc !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset gv=%b bd=%b pop=%h gvc=%0d required all 0",
                     grant_valid, burst_done, pop, grant_vc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_weights_empty();
        test_backpressure();
        test_single_idle();
        test_enable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
